// File: rtl/seven_seg_scan_pkg.sv
// Shared definitions for the stopwatch seven-segment scanner.
// Glyphs are active-low, bit 0 = segment a ... bit 6 = segment g.
package seven_seg_scan_pkg;

    localparam int NUM_DIGITS = 3;

    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_e;

endpackage

// File: rtl/seven_seg_scan_bcd_to_7seg.sv
// Combinational BCD to active-low seven-segment decoder.
// Non-BCD codes (10..15) render as a dash so bad timer data is visible.
module bcd_to_7seg
    import seven_seg_scan_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan.sv
// Three-digit multiplexed display driver: per-slot blanking guard, frame-coherent
// input snapshot and leading-zero suppression. All pins are registered.
module seven_seg_scan
    import seven_seg_scan_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int REFRESH_HZ   = 1000,
    parameter int BLANK_CYCLES = 64
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_digit1,
    input  logic [3:0] i_digit2,
    input  logic [3:0] i_digit3,
    input  logic [2:0] i_dp,
    input  logic       i_lz_blank,
    output logic [6:0] o_seg,
    output logic       o_dp,
    output logic [2:0] o_en,
    output logic       o_frame,
    output state_e     o_state
);

    localparam int DWELL = CLK_HZ / REFRESH_HZ;
    localparam int CW    = $clog2(DWELL);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DWELL - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
    localparam logic [1:0]    SLOT_LAST = 2'(NUM_DIGITS - 1);

    state_e                         state_q, state_d;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic [1:0]                     slot_q, slot_d;
    logic [NUM_DIGITS-1:0][3:0]     snap_dig_q, snap_dig_d;
    logic [NUM_DIGITS-1:0]          snap_dp_q, snap_dp_d;
    logic                           snap_lz_q, snap_lz_d;
    logic [6:0]                     seg_q, seg_d;
    logic                           dp_q, dp_d;
    logic [2:0]                     en_q, en_d;
    logic                           frame_q, frame_d;

    logic       frame_start;
    logic       blank2, blank1, slot_hidden, show;
    logic [3:0] dig_mux;
    logic [6:0] glyph;

    assign frame_start = (slot_q == 2'd0) && (cnt_q == '0);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= ST_RESET;
            cnt_q      <= '0;
            slot_q     <= 2'd0;
            snap_dig_q <= '0;
            snap_dp_q  <= '0;
            snap_lz_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            slot_q     <= slot_d;
            snap_dig_q <= snap_dig_d;
            snap_dp_q  <= snap_dp_d;
            snap_lz_q  <= snap_lz_d;
        end
    end

    // state_q describes the phase of the current counter value
    always_comb begin
        cnt_d      = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        slot_d     = slot_q;
        if (cnt_q == CNT_LAST) begin
            slot_d = (slot_q == SLOT_LAST) ? 2'd0 : slot_q + 2'd1;
        end
        state_d    = (cnt_d < BLANK_END) ? ST_BLANK : ST_SHOW;
        snap_dig_d = snap_dig_q;
        snap_dp_d  = snap_dp_q;
        snap_lz_d  = snap_lz_q;
        if (frame_start) begin
            snap_dig_d = {i_digit3, i_digit2, i_digit1};
            snap_dp_d  = i_dp;
            snap_lz_d  = i_lz_blank;
        end
    end

    assign dig_mux = snap_dig_q[slot_q];

    bcd_to_7seg u_dec (
        .i_bcd (dig_mux),
        .o_seg (glyph)
    );

    // A hidden leading zero keeps its slot dark for the whole dwell
    always_comb begin
        blank2      = snap_lz_q && (snap_dig_q[2] == 4'd0);
        blank1      = blank2 && (snap_dig_q[1] == 4'd0);
        slot_hidden = ((slot_q == 2'd2) && blank2) || ((slot_q == 2'd1) && blank1);
        show        = (state_q == ST_SHOW) && !slot_hidden;
        seg_d       = SEG_OFF;
        dp_d        = 1'b1;
        en_d        = 3'b111;
        frame_d     = frame_start;
        if (show) begin
            seg_d = glyph;
            dp_d  = ~snap_dp_q[slot_q];
            en_d  = ~(3'b001 << slot_q);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            seg_q   <= SEG_OFF;
            dp_q    <= 1'b1;
            en_q    <= 3'b111;
            frame_q <= 1'b0;
        end else begin
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            en_q    <= en_d;
            frame_q <= frame_d;
        end
    end

    assign o_seg   = seg_q;
    assign o_dp    = dp_q;
    assign o_en    = en_q;
    assign o_frame = frame_q;
    assign o_state = state_q;

endmodule
